// File: rtl/fc_pkg.sv
// Shared types for the branch-resolution flush controller.
package fc_pkg;

  typedef enum logic {IDLE, FLUSH} fc_state_t;

endpackage

// File: rtl/flush_controller_if.sv
// Fetch/EX-facing prediction, resolution and flush signals of the flush controller.
interface flush_controller_if #(
  parameter int unsigned WordSize   = 32,
  parameter int unsigned Depth      = 4,
  parameter int unsigned CountWidth = 16
);
  localparam int unsigned QcW = $clog2(Depth) + 1;

  logic                  pred_valid;
  logic                  pred_taken;
  logic [WordSize-1:0]   pred_target;
  logic [WordSize-1:0]   pred_fallthru;
  logic                  pred_ready;
  logic                  res_valid;
  logic                  res_taken;
  logic [WordSize-1:0]   res_target;
  logic                  flush;
  logic [WordSize-1:0]   npc_corr;
  logic [QcW-1:0]        queue_count;
  logic [CountWidth-1:0] mispredicts;
  logic                  underflow_err;

  modport master (
    output pred_valid, pred_taken, pred_target, pred_fallthru, res_valid, res_taken, res_target,
    input  pred_ready, flush, npc_corr, queue_count, mispredicts, underflow_err
  );

  modport slave (
    input  pred_valid, pred_taken, pred_target, pred_fallthru, res_valid, res_taken, res_target,
    output pred_ready, flush, npc_corr, queue_count, mispredicts, underflow_err
  );

endinterface

// File: rtl/pred_fifo.sv
// Circular in-order buffer of outstanding branch predictions; clear has priority over push.
module pred_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

endmodule

// File: rtl/flush_controller.sv
// Resolves queued branch predictions against EX outcomes and issues a timed flush with npc_corr.
module flush_controller
  import fc_pkg::*;
#(
  parameter int unsigned WordSize    = 32,
  parameter int unsigned Depth       = 4,
  parameter int unsigned FlushCycles = 2,
  parameter int unsigned CountWidth  = 16
) (
  input  logic               clk,
  input  logic               rst,
  flush_controller_if.slave  bus
);
  localparam int unsigned QcW  = $clog2(Depth) + 1;
  localparam int unsigned CntW = $clog2(FlushCycles + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(FlushCycles - 1);

  typedef struct packed {
    logic                taken;
    logic [WordSize-1:0] target;
    logic [WordSize-1:0] fallthru;
  } pred_entry_t;

  fc_state_t             state_q;
  logic [CntW-1:0]       flush_cnt_q;
  logic                  flush_q;
  logic [WordSize-1:0]   npc_corr_q;
  logic [CountWidth-1:0] mispredicts_q;
  logic                  underflow_q;

  pred_entry_t         head, wentry;
  logic [QcW-1:0]      fifo_count;
  logic                fifo_full, fifo_empty;
  logic                ready, push, pop, res_fire, mispredict;
  logic [WordSize-1:0] actual_pc, pred_pc;

  assign wentry = '{taken: bus.pred_taken, target: bus.pred_target,
                    fallthru: bus.pred_fallthru};

  always_comb begin
    ready      = (state_q == IDLE) && !fifo_full;
    push       = bus.pred_valid && ready;
    res_fire   = (state_q == IDLE) && bus.res_valid && !fifo_empty;
    actual_pc  = bus.res_taken ? bus.res_target : head.fallthru;
    pred_pc    = head.taken ? head.target : head.fallthru;
    mispredict = res_fire && (actual_pc != pred_pc);
    pop        = res_fire && !mispredict;
  end

  pred_fifo #(
    .Width ($bits(pred_entry_t)),
    .Depth (Depth)
  ) u_pred_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .wdata (wentry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      flush_cnt_q   <= '0;
      flush_q       <= 1'b0;
      npc_corr_q    <= '0;
      mispredicts_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q     <= FLUSH;
            flush_q     <= 1'b1;
            npc_corr_q  <= actual_pc;
            flush_cnt_q <= CntInit;
            if (mispredicts_q != '1) mispredicts_q <= mispredicts_q + CountWidth'(1);
          end else if (bus.res_valid && fifo_empty) begin
            underflow_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pred_ready    = ready;
  assign bus.flush         = flush_q;
  assign bus.npc_corr      = npc_corr_q;
  assign bus.queue_count   = fifo_count;
  assign bus.mispredicts   = mispredicts_q;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_flush_controller.sv
// Scoreboard bench for flush_controller: a reference queue model predicts every resolve outcome.
module tb_flush_controller;

  localparam int unsigned WordSize    = 32;
  localparam int unsigned Depth       = 4;
  localparam int unsigned FlushCycles = 2;
  localparam int unsigned CountWidth  = 16;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthru;
  } ent_t;

  typedef struct {
    logic        fl;
    logic [31:0] npc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flush_controller_if #(
    .WordSize   (WordSize),
    .Depth      (Depth),
    .CountWidth (CountWidth)
  ) bus ();

  flush_controller #(
    .WordSize    (WordSize),
    .Depth       (Depth),
    .FlushCycles (FlushCycles),
    .CountWidth  (CountWidth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        mq[$];
  res_t        sb_q[$];
  logic        m_flush;
  int          m_left;
  logic [31:0] m_npc;
  logic [15:0] m_mis;
  logic        m_under;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 1'b0;
    m_left  = 0;
    m_npc   = '0;
    m_mis   = '0;
    m_under = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".flush"}, 64'(bus.flush), 64'(m_flush));
    check_val({tag, ".npc"}, 64'(bus.npc_corr), 64'(m_npc));
    check_val({tag, ".count"}, 64'(bus.queue_count), 64'(mq.size()));
    check_val({tag, ".mis"}, 64'(bus.mispredicts), 64'(m_mis));
    check_val({tag, ".under"}, 64'(bus.underflow_err), 64'(m_under));
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic cycle(input string tag, input logic pv, input logic pt, input logic [31:0] ptg,
                       input logic [31:0] pft, input logic rv, input logic rt,
                       input logic [31:0] rtg);
    logic        exp_ready, resolved, mis;
    logic [31:0] act, prd;
    ent_t        h, e;
    bus.pred_valid    = pv;
    bus.pred_taken    = pt;
    bus.pred_target   = ptg;
    bus.pred_fallthru = pft;
    bus.res_valid     = rv;
    bus.res_taken     = rt;
    bus.res_target    = rtg;
    #1;
    exp_ready = !m_flush && (mq.size() < Depth);
    check_val({tag, ".ready"}, 64'(bus.pred_ready), 64'(exp_ready));
    resolved = 1'b0;
    mis      = 1'b0;
    e.taken = pt; e.target = ptg; e.fallthru = pft;
    if (!m_flush) begin
      if (rv && mq.size() > 0) begin
        h   = mq[0];
        act = rt ? rtg : h.fallthru;
        prd = h.taken ? h.target : h.fallthru;
        resolved = 1'b1;
        if (act != prd) begin
          mis = 1'b1;
          mq.delete();
          m_flush = 1'b1;
          m_left  = FlushCycles - 1;
          m_npc   = act;
          if (m_mis != 16'hffff) m_mis = m_mis + 16'd1;
        end else begin
          void'(mq.pop_front());
        end
        sb_q.push_back('{fl: mis, npc: m_npc});
      end else if (rv) begin
        m_under = 1'b1;
      end
      if (pv && exp_ready && !mis) mq.push_back(e);
    end else if (m_left == 0) begin
      m_flush = 1'b0;
    end else begin
      m_left--;
    end
    @(posedge clk);
    #1;
    if (resolved) begin
      res_t r;
      r = sb_q.pop_front();
      check_val({tag, ".sb_flush"}, 64'(bus.flush), 64'(r.fl));
      check_val({tag, ".sb_npc"}, 64'(bus.npc_corr), 64'(r.npc));
    end
    check_state(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_target = 0; bus.pred_fallthru = 0;
    bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    check_val("reset.ready", 64'(bus.pred_ready), 64'd1);
    rst = 1'b0;

    // Correct prediction, taken
    cycle("t1_push", 1, 1, 32'h100, 32'h14, 0, 0, 0);
    cycle("t1_res", 0, 0, 0, 0, 1, 1, 32'h100);

    // Not-taken predicted, actually taken
    cycle("t2_push", 1, 0, 32'h0, 32'h24, 0, 0, 0);
    cycle("t2_res", 1, 0, 0, 32'h28, 1, 1, 32'h200);
    idle("t2_flush", 3);

    // Fill, overflow attempt, pop, then pop+push at count 3
    for (int i = 0; i < 4; i++) cycle("t3_fill", 1, 0, 0, 32'h30 + 32'(i * 4), 0, 0, 0);
    cycle("t3_full", 1, 0, 0, 32'h99, 0, 0, 0);
    cycle("t3_pop", 0, 0, 0, 0, 1, 0, 32'h0);
    cycle("t3_popush", 1, 1, 32'h80, 32'h40, 1, 0, 32'h0);

    // Mispredict with three queued plus a concurrent push; res_valid during flush
    cycle("t4_mis", 1, 0, 0, 32'h44, 1, 1, 32'h500);
    cycle("t4_resfl", 0, 0, 0, 0, 1, 1, 32'h600);
    idle("t4_idle", 2);
    // Direction matches, target differs
    cycle("t4b_push", 1, 1, 32'h600, 32'h50, 0, 0, 0);
    cycle("t4b_res", 0, 0, 0, 0, 1, 1, 32'h604);
    idle("t4b_idle", 3);

    // Underflow
    cycle("t5_under", 0, 0, 0, 0, 1, 1, 32'h0);
    idle("t5_hold", 3);

    // Reset in first flush cycle
    cycle("t6_push", 1, 0, 0, 32'h60, 0, 0, 0);
    cycle("t6_mis", 0, 0, 0, 0, 1, 1, 32'h700);
    rst = 1'b1;
    #1;
    model_reset();
    check_state("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    idle("t6_post", 2);

    // Wrap: ten push/pop pairs around the circular buffer
    cycle("wrap_first", 1, 0, 0, 32'h1000, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      logic        t;
      logic [31:0] tg;
      t  = 1'($urandom_range(0, 1));
      tg = 32'h2000 + 32'(i * 16);
      cycle("wrap", 1, t, tg, 32'h1004 + 32'(i * 4), 1, mq[0].taken, mq[0].target);
    end
    cycle("wrap_last", 0, 0, 0, 0, 1, 1, 32'hdead0);
    idle("wrap_idle", 3);

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
